// File: rtl/memory_burst.sv
// Single-port RAM: self-clearing after reset, byte-lane writes, wrapping auto-increment bursts.
// Read data appears READ_LATENCY edges after its beat; Ready=0 while clearing or bursting, requests then ignored.
module memory_burst #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 16,
    parameter int DEPTH        = 256,
    parameter int READ_LATENCY = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    R_W,
    input  logic [ADDR_WIDTH-1:0]   Address,
    input  logic [3:0]              Burst_Len,
    input  logic [DATA_WIDTH-1:0]   D_In,
    input  logic [DATA_WIDTH/8-1:0] Byte_En,
    output logic                    Ready,
    output logic [DATA_WIDTH-1:0]   D_Out,
    output logic                    Valid_Out,
    output logic                    Err
);
    localparam int NB = DATA_WIDTH / 8;
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IW-1:0]       LAST_ADDR = IW'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0] DEPTH_A   = (ADDR_WIDTH + 1)'(DEPTH);

    typedef enum logic [1:0] {S_INIT, S_IDLE, S_BURST} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   clr_cnt_q, clr_cnt_d;
    logic [IW-1:0]   addr_q, addr_d;
    logic [3:0]      left_q, left_d;
    logic            rw_q, rw_d;
    logic            err_q, err_d;

    logic [DATA_WIDTH-1:0] Mem [DEPTH];

    logic                  beat;
    logic                  beat_rw;
    logic [IW-1:0]         beat_addr;
    logic                  mem_we;
    logic [IW-1:0]         mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdat;
    logic [NB-1:0]         mem_be;

    logic [READ_LATENCY-1:0] vld_q;
    logic [DATA_WIDTH-1:0]   dat_q [READ_LATENCY];

    function automatic logic [IW-1:0] next_addr(input logic [IW-1:0] a);
        return (a == LAST_ADDR) ? '0 : a + IW'(1);
    endfunction

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        addr_d    = addr_q;
        left_d    = left_q;
        rw_d      = rw_q;
        err_d     = 1'b0;
        Ready     = 1'b0;
        beat      = 1'b0;
        beat_rw   = 1'b0;
        beat_addr = addr_q;
        mem_we    = 1'b0;
        mem_waddr = clr_cnt_q;
        mem_wdat  = D_In;
        mem_be    = Byte_En;
        case (state_q)
            S_INIT: begin
                mem_we    = 1'b1;
                mem_wdat  = '0;
                mem_be    = '1;
                clr_cnt_d = clr_cnt_q + IW'(1);
                if (clr_cnt_q == LAST_ADDR) begin
                    state_d   = S_IDLE;
                    clr_cnt_d = '0;
                end
            end
            S_IDLE: begin
                Ready = 1'b1;
                if (enable) begin
                    // Only the start address is range-checked; burst addresses wrap.
                    if ({1'b0, Address} >= DEPTH_A) begin
                        err_d = 1'b1;
                    end else begin
                        beat      = 1'b1;
                        beat_rw   = R_W;
                        beat_addr = Address[IW-1:0];
                        if (Burst_Len != 4'd0) begin
                            state_d = S_BURST;
                            rw_d    = R_W;
                            left_d  = Burst_Len;
                            addr_d  = next_addr(Address[IW-1:0]);
                        end
                    end
                end
            end
            S_BURST: begin
                beat      = 1'b1;
                beat_rw   = rw_q;
                beat_addr = addr_q;
                addr_d    = next_addr(addr_q);
                left_d    = left_q - 4'd1;
                if (left_q == 4'd1) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_INIT;
        endcase
        if (beat && beat_rw) begin
            mem_we    = 1'b1;
            mem_waddr = beat_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_INIT;
            clr_cnt_q <= '0;
            addr_q    <= '0;
            left_q    <= '0;
            rw_q      <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            addr_q    <= addr_d;
            left_q    <= left_d;
            rw_q      <= rw_d;
            err_q     <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && mem_we) begin
            for (int i = 0; i < NB; i++) begin
                if (mem_be[i]) begin
                    Mem[mem_waddr][8*i +: 8] <= mem_wdat[8*i +: 8];
                end
            end
        end
    end

    // Data stages load only behind a valid, so the last stage holds D_Out between results.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                dat_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= beat && !beat_rw;
            if (beat && !beat_rw) begin
                dat_q[0] <= Mem[beat_addr];
            end
            for (int i = 1; i < READ_LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
                if (vld_q[i-1]) begin
                    dat_q[i] <= dat_q[i-1];
                end
            end
        end
    end

    assign Valid_Out = vld_q[READ_LATENCY-1];
    assign D_Out     = dat_q[READ_LATENCY-1];
    assign Err       = err_q;

endmodule

// File: tb/tb_memory_burst.sv
// Bench for memory_burst: two instances (read latency 1 and 3) share one stimulus stream.
module tb_memory_burst;
    localparam int DEP = 16;
    localparam int LAT [2] = '{1, 3};

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        R_W = 1'b0;
    logic [15:0] Address = '0;
    logic [3:0]  Burst_Len = '0;
    logic [31:0] D_In = '0;
    logic [3:0]  Byte_En = '0;
    logic [1:0]  rdy, vld, err;
    logic [31:0] dout [2];

    always #5 clk = ~clk;

    memory_burst #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .DEPTH(DEP), .READ_LATENCY(1)) u_dut1 (
        .clk(clk), .reset(reset), .enable(enable), .R_W(R_W), .Address(Address),
        .Burst_Len(Burst_Len), .D_In(D_In), .Byte_En(Byte_En), .Ready(rdy[0]),
        .D_Out(dout[0]), .Valid_Out(vld[0]), .Err(err[0]));

    memory_burst #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .DEPTH(DEP), .READ_LATENCY(3)) u_dut3 (
        .clk(clk), .reset(reset), .enable(enable), .R_W(R_W), .Address(Address),
        .Burst_Len(Burst_Len), .D_In(D_In), .Byte_En(Byte_En), .Ready(rdy[1]),
        .D_Out(dout[1]), .Valid_Out(vld[1]), .Err(err[1]));

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    logic [31:0] model_mem [DEP];
    logic [31:0] exp_q [$];
    int          exp_c [$];
    int          exp_err;
    logic [31:0] obs_q [2][$];
    int          obs_c [2][$];
    int          err_cnt [2];
    logic [31:0] beat_dat [16];
    logic [3:0]  beat_be [16];
    logic        rdy_trace [16];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (vld[d] === 1'b1) begin
                obs_q[d].push_back(dout[d]);
                obs_c[d].push_back(cyc);
            end
            if (err[d] === 1'b1) err_cnt[d]++;
        end
    end

    task automatic clear_obs();
        exp_q.delete();
        exp_c.delete();
        exp_err = 0;
        for (int d = 0; d < 2; d++) begin
            obs_q[d].delete();
            obs_c[d].delete();
            err_cnt[d] = 0;
        end
    endtask

    // Drives one request (called with Ready=1, #1 after an edge) and updates the reference model.
    task automatic do_req(input logic rw, input logic [15:0] a, input logic [3:0] bl);
        int ma;
        enable = 1'b1;
        R_W = rw;
        Address = a;
        Burst_Len = bl;
        for (int b = 0; b <= int'(bl); b++) begin
            D_In = beat_dat[b];
            Byte_En = beat_be[b];
            @(posedge clk);
            #1;
            enable = 1'b0;
            rdy_trace[b] = rdy[0];
            if (int'(a) >= DEP) begin
                exp_err++;
                break;
            end
            ma = (int'(a) + b) % DEP;
            if (rw) begin
                for (int i = 0; i < 4; i++)
                    if (beat_be[b][i]) model_mem[ma][8*i +: 8] = beat_dat[b][8*i +: 8];
            end else begin
                exp_q.push_back(model_mem[ma]);
                exp_c.push_back(cyc);
            end
        end
        enable = 1'b0;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (rdy[0] !== 1'b1 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic drain();
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int n;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        tests++; if (rdy !== 2'b00) begin fails++; $display("FAIL reset_ready: got %b expected 00", rdy); end
        tests++; if (vld !== 2'b00) begin fails++; $display("FAIL reset_valid: got %b expected 00", vld); end
        tests++; if (err !== 2'b00) begin fails++; $display("FAIL reset_err: got %b expected 00", err); end
        tests++; if (dout[0] !== 32'h0 || dout[1] !== 32'h0) begin
            fails++; $display("FAIL reset_dout: got %h/%h expected 0", dout[0], dout[1]);
        end
        reset = 1'b0;
        wait_ready(n);
        tests++; if (n != DEP || rdy !== 2'b11) begin
            fails++; $display("FAIL reset_init_cycles: got %0d ready=%b expected %0d ready=11", n, rdy, DEP);
        end
        for (int i = 0; i < DEP; i++) model_mem[i] = 32'h0;
        // Fill everything with ones, then check a one-cycle reset wipes it.
        for (int i = 0; i < 16; i++) begin beat_dat[i] = 32'hFFFF_FFFF; beat_be[i] = 4'hF; end
        do_req(1'b1, 16'd0, 4'd15);
        tests++; if (u_dut3.Mem[9] !== 32'hFFFF_FFFF) begin
            fails++; $display("FAIL preload: got %h expected ffffffff", u_dut3.Mem[9]);
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < DEP; i++) model_mem[i] = 32'h0;
        wait_ready(n);
        tests++; if (n != DEP) begin fails++; $display("FAIL reclear_cycles: got %0d expected %0d", n, DEP); end
        n = 0;
        for (int i = 0; i < DEP; i++)
            if (u_dut1.Mem[i] !== 32'h0 || u_dut3.Mem[i] !== 32'h0) n++;
        tests++; if (n != 0) begin fails++; $display("FAIL reclear_mem: got %0d nonzero words expected 0", n); end
    endtask

    task automatic test_single();
        logic [31:0] vals [8];
        vals = '{32'hAAAA0000, 32'h00AA0000, 32'h0000AA00, 32'h000000AA,
                 32'h12345678, 32'hDEADBEEF, 32'h0F0F0F0F, 32'hFFFF0000};
        clear_obs();
        for (int i = 0; i < 8; i++) begin
            beat_dat[0] = vals[i]; beat_be[0] = 4'hF;
            do_req(1'b1, 16'(i), 4'd0);
        end
        for (int i = 0; i < 8; i++) do_req(1'b0, 16'(i), 4'd0);
        drain();
        for (int d = 0; d < 2; d++) begin
            tests++; if (obs_q[d].size() != 8) begin
                fails++; $display("FAIL single_count lat%0d: got %0d expected 8", LAT[d], obs_q[d].size());
            end
            for (int i = 0; i < 8 && i < obs_q[d].size(); i++) begin
                tests++; if (obs_q[d][i] !== vals[i] || obs_c[d][i] != exp_c[0] + i + LAT[d] - 1) begin
                    fails++; $display("FAIL single_read lat%0d[%0d]: got %h@%0d expected %h@%0d",
                        LAT[d], i, obs_q[d][i], obs_c[d][i], vals[i], exp_c[0] + i + LAT[d] - 1);
                end
            end
            tests++; if (dout[d] !== vals[7] || vld[d] !== 1'b0) begin
                fails++; $display("FAIL dout_hold lat%0d: got %h vld=%b expected %h vld=0", LAT[d], dout[d], vld[d], vals[7]);
            end
        end
    endtask

    task automatic test_byte_lanes();
        clear_obs();
        beat_dat[0] = 32'h11223344; beat_be[0] = 4'hF;
        do_req(1'b1, 16'd5, 4'd0);
        beat_dat[0] = 32'hAABBCCDD; beat_be[0] = 4'b0101;
        do_req(1'b1, 16'd5, 4'd0);
        do_req(1'b0, 16'd5, 4'd0);
        beat_dat[0] = 32'h55555555; beat_be[0] = 4'b0000;
        do_req(1'b1, 16'd5, 4'd0);
        do_req(1'b0, 16'd5, 4'd0);
        drain();
        for (int d = 0; d < 2; d++) begin
            tests++; if (obs_q[d].size() != 2) begin
                fails++; $display("FAIL bytes_count lat%0d: got %0d expected 2", LAT[d], obs_q[d].size());
            end else begin
                tests++; if (obs_q[d][0] !== 32'h11BB33DD || obs_q[d][1] !== 32'h11BB33DD) begin
                    fails++; $display("FAIL byte_lanes lat%0d: got %h,%h expected 11bb33dd,11bb33dd",
                        LAT[d], obs_q[d][0], obs_q[d][1]);
                end
            end
        end
    endtask

    task automatic test_wrap();
        clear_obs();
        for (int i = 0; i < 4; i++) begin beat_dat[i] = 32'(i + 1); beat_be[i] = 4'hF; end
        do_req(1'b1, 16'd14, 4'd3);
        tests++; if (rdy_trace[0] !== 1'b0 || rdy_trace[1] !== 1'b0 || rdy_trace[2] !== 1'b0 || rdy_trace[3] !== 1'b1) begin
            fails++; $display("FAIL wrap_ready: got %b%b%b%b expected 0001",
                rdy_trace[0], rdy_trace[1], rdy_trace[2], rdy_trace[3]);
        end
        tests++; if (u_dut1.Mem[14] !== 32'd1 || u_dut1.Mem[15] !== 32'd2 || u_dut1.Mem[0] !== 32'd3 || u_dut1.Mem[1] !== 32'd4) begin
            fails++; $display("FAIL wrap_mem: got %h %h %h %h expected 1 2 3 4",
                u_dut1.Mem[14], u_dut1.Mem[15], u_dut1.Mem[0], u_dut1.Mem[1]);
        end
        do_req(1'b0, 16'd14, 4'd3);
        drain();
        for (int d = 0; d < 2; d++) begin
            tests++; if (obs_q[d].size() != 4) begin
                fails++; $display("FAIL wrap_count lat%0d: got %0d expected 4", LAT[d], obs_q[d].size());
            end
            for (int i = 0; i < 4 && i < obs_q[d].size(); i++) begin
                tests++; if (obs_q[d][i] !== 32'(i + 1) || obs_c[d][i] != exp_c[0] + i + LAT[d] - 1) begin
                    fails++; $display("FAIL wrap_read lat%0d[%0d]: got %h@%0d expected %h@%0d",
                        LAT[d], i, obs_q[d][i], obs_c[d][i], i + 1, exp_c[0] + i + LAT[d] - 1);
                end
            end
        end
    endtask

    task automatic test_range();
        clear_obs();
        do_req(1'b0, 16'd16, 4'd0);
        tests++; if (err !== 2'b11 || rdy !== 2'b11) begin
            fails++; $display("FAIL range_err: got err=%b ready=%b expected 11/11", err, rdy);
        end
        do_req(1'b0, 16'd3, 4'd0);
        tests++; if (err !== 2'b00) begin fails++; $display("FAIL range_err_width: got %b expected 00", err); end
        drain();
        for (int d = 0; d < 2; d++) begin
            tests++; if (err_cnt[d] != 1 || obs_q[d].size() != 1) begin
                fails++; $display("FAIL range_counts lat%0d: got err=%0d reads=%0d expected 1/1", LAT[d], err_cnt[d], obs_q[d].size());
            end else begin
                tests++; if (obs_q[d][0] !== model_mem[3]) begin
                    fails++; $display("FAIL range_next lat%0d: got %h expected %h", LAT[d], obs_q[d][0], model_mem[3]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int bad;
        clear_obs();
        for (int r = 0; r < 60; r++) begin
            for (int i = 0; i < 16; i++) begin beat_dat[i] = $urandom; beat_be[i] = 4'($urandom_range(0, 15)); end
            do_req(1'($urandom_range(0, 1)), 16'($urandom_range(0, 17)), 4'($urandom_range(0, 6)));
            if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
        end
        drain();
        for (int d = 0; d < 2; d++) begin
            tests++; if (obs_q[d].size() != exp_q.size() || err_cnt[d] != exp_err) begin
                fails++; $display("FAIL rand_counts lat%0d: got reads=%0d errs=%0d expected %0d/%0d",
                    LAT[d], obs_q[d].size(), err_cnt[d], exp_q.size(), exp_err);
            end
            bad = 0;
            for (int i = 0; i < exp_q.size() && i < obs_q[d].size(); i++) begin
                if (obs_q[d][i] !== exp_q[i] || obs_c[d][i] != exp_c[i] + LAT[d] - 1) begin
                    if (bad < 4) $display("FAIL rand_read lat%0d[%0d]: got %h@%0d expected %h@%0d",
                        LAT[d], i, obs_q[d][i], obs_c[d][i], exp_q[i], exp_c[i] + LAT[d] - 1);
                    bad++;
                end
            end
            tests++; if (bad != 0) begin fails++; $display("FAIL rand_stream lat%0d: got %0d bad beats expected 0", LAT[d], bad); end
        end
        bad = 0;
        for (int i = 0; i < DEP; i++)
            if (u_dut1.Mem[i] !== model_mem[i] || u_dut3.Mem[i] !== model_mem[i]) bad++;
        tests++; if (bad != 0) begin fails++; $display("FAIL rand_mem: got %0d differing words expected 0", bad); end
    endtask

    task automatic test_reset_mid_burst();
        int rc, n, bad, want;
        clear_obs();
        enable = 1'b1; R_W = 1'b0; Address = 16'd0; Burst_Len = 4'd7;
        for (int b = 0; b < 3; b++) begin
            @(posedge clk);
            #1;
            enable = 1'b0;
            exp_q.push_back(model_mem[b]);
            exp_c.push_back(cyc);
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        rc = cyc;
        reset = 1'b0;
        for (int i = 0; i < DEP; i++) model_mem[i] = 32'h0;
        tests++; if (vld !== 2'b00 || dout[0] !== 32'h0 || dout[1] !== 32'h0) begin
            fails++; $display("FAIL midrst_flush: got vld=%b dout=%h/%h expected 00, 0/0", vld, dout[0], dout[1]);
        end
        n = 0; bad = 0;
        while (rdy[0] !== 1'b1 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (vld !== 2'b00) bad++;
        end
        tests++; if (n != DEP || bad != 0) begin
            fails++; $display("FAIL midrst_init: got %0d cycles %0d valids expected %0d/0", n, bad, DEP);
        end
        for (int d = 0; d < 2; d++) begin
            want = 0;
            foreach (exp_c[i]) if (exp_c[i] + LAT[d] - 1 < rc) want++;
            bad = (obs_q[d].size() != want) ? 1 : 0;
            for (int i = 0; i < want && i < obs_q[d].size(); i++) if (obs_q[d][i] !== exp_q[i]) bad++;
            tests++; if (bad != 0) begin
                fails++; $display("FAIL midrst_reads lat%0d: got %0d reads expected %0d matching", LAT[d], obs_q[d].size(), want);
            end
        end
        clear_obs();
        do_req(1'b0, 16'd2, 4'd0);
        drain();
        tests++; if (obs_q[0].size() != 1 || obs_q[1].size() != 1 || obs_q[0][0] !== 32'h0 || obs_q[1][0] !== 32'h0) begin
            fails++; $display("FAIL midrst_cleared: got %0d/%0d reads expected one zero each", obs_q[0].size(), obs_q[1].size());
        end
    endtask

    initial begin
        clear_obs();
        test_reset();
        test_single();
        test_byte_lanes();
        test_wrap();
        test_range();
        test_back_to_back();
        test_reset_mid_burst();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        fails++;
        $display("FAIL timeout: got no completion expected finish before 500000");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "timeout");
    end

endmodule
